sha256_msg_schedule_ctrl: RTL and testbench
===========================================

// Module: sha256_msg_schedule_ctrl
// PURPOSE
//  Sequencer for the SHA-256 message schedule. Accepts the 16 words of one 512-bit block
//  over a valid/ready input stream, then streams W[0..63] to the compression-round engine
//  over a valid/ready output stream, one word per accepted beat.
//  Words W[16..63] are expanded in place in a 16-entry sliding window:
//  W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] (mod 2^32).
// PARAMETERS
//  WORD_W       32  word width; fixed by SHA-256, no other value supported
//  BLOCK_WORDS  16  words per message block = window depth
//  NUM_ROUNDS   64  schedule words emitted per block
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous reset, active-high
//  in_valid   in   1   in_word valid
//  in_ready   out  1   controller accepts a word this cycle
//  in_word    in   32  message word, big-endian order, W[0] first
//  out_valid  out  1   out_word valid
//  out_ready  in   1   round engine accepts out_word
//  out_word   out  32  W[t]
//  out_round  out  6   t (0..63) of out_word
//  out_last   out  1   high with out_valid when t == 63
//  busy       out  1   high in LOAD (after 1st word) and RUN
// BEHAVIOUR
//  - Reset (async assert, sync deassert use): state = LOAD, load_cnt = 0, round_cnt = 0,
//    window cleared to 0. Outputs: in_ready = 1, out_valid = 0, out_word = 0, out_round = 0,
//    out_last = 0, busy = 0.
//  - States: LOAD, RUN. No separate IDLE; LOAD with load_cnt == 0 is idle.
//  - LOAD
//    - in_ready = 1, out_valid = 0.
//    - On in_valid & in_ready: win[load_cnt] <= in_word; load_cnt++.
//    - The accept with load_cnt == 15 moves to RUN next cycle, round_cnt = 0.
//  - RUN
//    - in_ready = 0; out_valid = 1; out_word = win[0]; out_round = round_cnt.
//    - All out_* are registered/stable while out_ready = 0: no change, no expansion.
//    - On out_valid & out_ready:
//      - shift win[i] <= win[i+1] for i = 0..14.
//      - win[15] <= s1(win[14]) + win[9] + s0(win[1]) + win[0], truncated to 32 bits.
//      - round_cnt++.
//    - Expansion also runs for t >= 48; the surplus words are discarded. The datapath stays uniform.
//  - Latency: first out_valid the cycle after the 16th input accept. With out_ready held at 1,
//    the block drains in exactly 64 cycles, at 1 word per cycle.
//  - Accepting the beat with out_last = 1 (round 63): next cycle state = LOAD, load_cnt = 0,
//    in_ready = 1, out_valid = 0. There is no bubble beyond that single cycle.
//  - Input offered during RUN is ignored (in_ready = 0). The source must hold in_valid/in_word.
//  - rst asserted mid-LOAD or mid-RUN: immediate return to the reset state, partial block discarded.
//    out_valid drops asynchronously.
//  - s0(x) = ROTR7 ^ ROTR18 ^ SHR3.  s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
//  - All additions are modulo 2^32; carries are dropped.
//  - Counters: load_cnt is 4 bits, round_cnt is 6 bits. round_cnt wraps 63 -> 0 only on the
//    last accept, never otherwise.
// STRUCTURE
//  - Shared package sha256_pkg holds:
//    - WORD_W, BLOCK_WORDS, NUM_ROUNDS.
//    - typedef word_t [31:0].
//    - state enum {LOAD, RUN}.
//    - rotation constants 7/18/3 and 17/19/10.
//  - One sub-module: sha256_sched_sigma. Combinational, takes x_s0 and x_s1, returns s0 and s1.
//    Instantiated once, fed win[1] and win[14].
//  - The top holds the FSM, both counters, the 16x32 window and the 4-input adder.
// TESTING
//  1. "abc" block (W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018), out_ready = 1
//     -> W16 = 0x61626380, W17 = 0x000F0000, W63 = 0x12B1EDEB.
//     -> out_last only at out_round = 63.
//  2. Random out_ready backpressure on a random block -> out_word/out_round stable while stalled.
//     -> Sequence matches the reference model and is 64 beats exactly.
//  3. Gapped in_valid (1 word every 3 cycles) -> first out_valid the cycle after the 16th accept.
//     -> in_ready = 0 throughout RUN.
//  4. Two back-to-back blocks -> in_ready = 1 the cycle after the out_last accept.
//     -> Second block words are correct (no window residue).
//  5. rst pulse at round 30, then a new block -> out_valid = 0 immediately.
//     -> Reload starts at W[0] and the new schedule is correct.
//  6. All-ones block (16 x 0xFFFFFFFF) -> modulo-2^32 wrap correct vs model for all 64 words.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-schedule types, sizes and rotation helpers.
package sha256_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BLOCK_WORDS = 16;
    localparam int unsigned NUM_ROUNDS  = 64;
    localparam int unsigned LOAD_CNT_W  = 4;
    localparam int unsigned ROUND_W     = 6;

    // Small-sigma rotate/shift amounts.
    localparam int unsigned S0_ROT_A = 7;
    localparam int unsigned S0_ROT_B = 18;
    localparam int unsigned S0_SHR   = 3;
    localparam int unsigned S1_ROT_A = 17;
    localparam int unsigned S1_ROT_B = 19;
    localparam int unsigned S1_SHR   = 10;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

endpackage

// File: rtl/sha256_sched_sigma.sv
// Combinational small-sigma pair used by the schedule expansion.
module sha256_sched_sigma
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] x_s0,
    input  logic [WORD_W-1:0] x_s1,
    output logic [WORD_W-1:0] s0,
    output logic [WORD_W-1:0] s1
);

    assign s0 = rotr(x_s0, S0_ROT_A) ^ rotr(x_s0, S0_ROT_B) ^ (x_s0 >> S0_SHR);
    assign s1 = rotr(x_s1, S1_ROT_A) ^ rotr(x_s1, S1_ROT_B) ^ (x_s1 >> S1_SHR);

endmodule

// File: rtl/sha256_msg_schedule_ctrl.sv
// Loads one 16-word block, then streams W[0..63] while expanding in a 16-deep window.
module sha256_msg_schedule_ctrl
    import sha256_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_word,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_W-1:0]   out_word,
    output logic [ROUND_W-1:0]  out_round,
    output logic                out_last,
    output logic                busy
);

    localparam logic [LOAD_CNT_W-1:0] LOAD_LAST  = LOAD_CNT_W'(BLOCK_WORDS - 1);
    localparam logic [ROUND_W-1:0]    ROUND_PRE  = ROUND_W'(NUM_ROUNDS - 2);
    localparam logic [ROUND_W-1:0]    ROUND_LAST = ROUND_W'(NUM_ROUNDS - 1);

    state_t                  r_state;
    logic [LOAD_CNT_W-1:0]   r_load_cnt;
    logic [ROUND_W-1:0]      r_round_cnt;
    word_t                   r_win [BLOCK_WORDS];
    logic                    r_in_ready;
    logic                    r_out_valid;
    word_t                   r_out_word;
    logic                    r_out_last;
    logic                    r_busy;

    word_t                   w_s0;
    word_t                   w_s1;
    word_t                   w_next;
    logic                    w_in_fire;
    logic                    w_out_fire;

    sha256_sched_sigma u_sigma (
        .x_s0 (r_win[1]),
        .x_s1 (r_win[14]),
        .s0   (w_s0),
        .s1   (w_s1)
    );

    // W[t+16] from the current window; carries beyond 32 bits drop naturally.
    assign w_next     = w_s1 + r_win[9] + w_s0 + r_win[0];
    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= LOAD;
            r_load_cnt  <= '0;
            r_round_cnt <= '0;
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                r_win[i] <= '0;
            end
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_in_fire) begin
                        r_win[r_load_cnt] <= in_word;
                        r_load_cnt        <= LOAD_CNT_W'(r_load_cnt + LOAD_CNT_W'(1));
                        r_busy            <= 1'b1;
                        if (r_load_cnt == LOAD_LAST) begin
                            // win[0] was filled by the first accept, so it is already W[0].
                            r_state     <= RUN;
                            r_round_cnt <= '0;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_word  <= r_win[0];
                            r_out_last  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (w_out_fire) begin
                        for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
                            r_win[i] <= r_win[i+1];
                        end
                        r_win[BLOCK_WORDS-1] <= w_next;
                        r_round_cnt          <= ROUND_W'(r_round_cnt + ROUND_W'(1));
                        if (r_round_cnt == ROUND_LAST) begin
                            r_state     <= LOAD;
                            r_load_cnt  <= '0;
                            r_in_ready  <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_out_word  <= '0;
                            r_out_last  <= 1'b0;
                            r_busy      <= 1'b0;
                        end else begin
                            r_out_word <= r_win[1];
                            r_out_last <= (r_round_cnt == ROUND_PRE);
                        end
                    end
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_word  = r_out_word;
    assign out_round = r_round_cnt;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

endmodule

// File: tb/tb_sha256_msg_schedule_ctrl.sv
// Randomized self-checking bench for the SHA-256 message schedule sequencer.
module tb_sha256_msg_schedule_ctrl;
    import sha256_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [5:0]  out_round;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int errors = 0;

    word_t blk  [16];
    word_t expw [64];
    word_t gotw [64];

    sha256_msg_schedule_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_round (out_round),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference: whole 64-word schedule straight from the defining recurrence.
    task automatic ref_schedule();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) expw[t] = blk[t];
            else expw[t] = (ror(expw[t-2], 17) ^ ror(expw[t-2], 19) ^ (expw[t-2] >> 10))
                         + expw[t-7]
                         + (ror(expw[t-15], 7) ^ ror(expw[t-15], 18) ^ (expw[t-15] >> 3))
                         + expw[t-16];
        end
    endtask

    task automatic rand_block();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
    endtask

    // Called at posedge+1; returns at posedge+1 after the 16th accept.
    task automatic load_block(input int gap);
        int idx = 0;
        int cyc = 0;
        while (idx < 16) begin
            check("load_in_ready", 32'(in_ready), 32'd1);
            check("load_out_valid", 32'(out_valid), 32'd0);
            check("load_busy", 32'(busy), (idx > 0) ? 32'd1 : 32'd0);
            in_valid = ((cyc % gap) == 0);
            in_word  = in_valid ? blk[idx] : 32'hDEAD_BEEF;
            @(posedge clk);
            if (in_valid && in_ready) idx++;
            #1;
            cyc++;
            if (cyc > 200) begin
                check("load_timeout", 32'(idx), 32'd16);
                return;
            end
        end
        // Source keeps offering junk during RUN; it must be ignored.
        in_valid = 1'b1;
        in_word  = $urandom;
        check("first_out_valid", 32'(out_valid), 32'd1);
        check("first_out_round", 32'(out_round), 32'd0);
    endtask

    // Drains beats [0..stop_at) with optional random backpressure.
    task automatic drain(input bit rand_ready, input int stop_at);
        int          beat = 0;
        int          cyc = 0;
        bit          stalled = 1'b0;
        logic [31:0] pw = '0;
        logic [5:0]  pr = '0;
        while (beat < stop_at) begin
            check("run_out_valid", 32'(out_valid), 32'd1);
            check("run_in_ready", 32'(in_ready), 32'd0);
            check("run_busy", 32'(busy), 32'd1);
            if (stalled) begin
                check("stall_word", out_word, pw);
                check("stall_round", 32'(out_round), 32'(pr));
            end
            check("out_word", out_word, expw[beat]);
            check("out_round", 32'(out_round), 32'(beat));
            check("out_last", 32'(out_last), (beat == 63) ? 32'd1 : 32'd0);
            gotw[beat] = out_word;
            pw = out_word;
            pr = out_round;
            out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(posedge clk);
            #1;
            stalled = !out_ready;
            if (out_ready) beat++;
            cyc++;
            if (cyc > 1000) begin
                check("drain_timeout", 32'(beat), 32'(stop_at));
                return;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (stop_at == 64) begin
            check("post_in_ready", 32'(in_ready), 32'd1);
            check("post_out_valid", 32'(out_valid), 32'd0);
            check("post_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_word = '0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_word", out_word, 32'd0);
        check("rst_out_round", 32'(out_round), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // "abc" known-answer block
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0]  = 32'h6162_6380;
        blk[15] = 32'h0000_0018;
        ref_schedule();
        load_block(1);
        drain(1'b0, 64);
        check("abc_w16", gotw[16], 32'h6162_6380);
        check("abc_w17", gotw[17], 32'h000F_0000);
        check("abc_w63", gotw[63], 32'h12B1_EDEB);

        // Random block with backpressure
        rand_block();
        ref_schedule();
        load_block(1);
        drain(1'b1, 64);

        // Gapped input
        rand_block();
        ref_schedule();
        load_block(3);
        drain(1'b0, 64);

        // Two back-to-back blocks
        for (int b = 0; b < 2; b++) begin
            rand_block();
            ref_schedule();
            load_block(1);
            drain(1'b1, 64);
        end

        // Reset mid-RUN at round 30
        rand_block();
        ref_schedule();
        load_block(1);
        drain(1'b0, 30);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_round", 32'(out_round), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rand_block();
        ref_schedule();
        load_block(2);
        drain(1'b1, 64);

        // All-ones block exercises carry wrap
        for (int i = 0; i < 16; i++) blk[i] = 32'hFFFF_FFFF;
        ref_schedule();
        load_block(1);
        drain(1'b0, 64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
